// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared state encoding and constants for the RV32I fetch stage.
package rv32i_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    REQ        = 2'd1,
    SKID       = 2'd2,
    FLUSH      = 2'd3
  } fetch_state_e;

  // addi x0, x0, 0 -- presented in place of an unfetchable instruction.
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Clear the byte-offset bits of an address.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32i_fetch_skid.sv
// rv32i_fetch_skid: one-entry holding register for an instruction that
// arrived while decode was stalled. Clear and unload both empty it.
module rv32i_fetch_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  input  logic        i_unload,
  input  logic        i_clear,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst,
  output logic        o_valid
);

  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_valid;

  // Capture on load; emptying wins over a simultaneous load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= 32'd0;
      r_inst  <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_clear || i_unload) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_pc    <= i_pc;
      r_inst  <= i_inst;
      r_valid <= 1'b1;
    end
  end

  assign o_pc    = r_pc;
  assign o_inst  = r_inst;
  assign o_valid = r_valid;

endmodule

// File: rtl/rv32i_fetch.sv
// rv32i_fetch: RV32I instruction fetch stage with one outstanding request,
// a one-entry skid buffer for stalls and redirect flushing.
// Optional feature: define RV32I_FETCH_MISALIGN_EN to turn a redirect to a
// non-word-aligned target into a held NOP with the misaligned flag raised
// instead of a memory request. Without it the target's low bits are ignored.
module rv32i_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        i_inst_req,
  output logic [31:0] i_inst_addr,
  input  logic        i_inst_ack,
  input  logic [31:0] i_inst_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        misaligned
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;

  logic        r_req,        w_req_next;
  logic [31:0] r_addr,       w_addr_next;
  logic [31:0] r_pc,         w_pc_next;
  logic [31:0] r_inst,       w_inst_next;
  logic        r_valid,      w_valid_next;
  logic        r_mis,        w_mis_next;
  logic [31:0] r_target,     w_target_next;
  logic        r_target_mis, w_target_mis_next;

  logic        w_ack;
  logic [31:0] w_tgt_pc;
  logic        w_tgt_mis;
  logic [31:0] w_src_pc;
  logic        w_src_mis;
  logic        w_launch;

  logic        w_skid_load;
  logic        w_skid_unload;
  logic        w_skid_clear;
  logic [31:0] w_skid_pc;
  logic [31:0] w_skid_inst;
  logic        w_skid_valid;

  // An ack only counts against a request we actually have outstanding.
  assign w_ack = r_req & i_inst_ack;

`ifdef RV32I_FETCH_MISALIGN_EN
  assign w_tgt_pc  = redirect_pc;
  assign w_tgt_mis = (redirect_pc[1:0] != 2'b00);
`else
  logic w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = ^redirect_pc[1:0];
  assign w_tgt_pc  = word_align(redirect_pc);
  assign w_tgt_mis = 1'b0;
`endif

  // In FLUSH the saved target is used unless a newer redirect arrives now.
  assign w_src_pc  = (r_state == FLUSH && !redirect) ? r_target     : w_tgt_pc;
  assign w_src_mis = (r_state == FLUSH && !redirect) ? r_target_mis : w_tgt_mis;

  rv32i_fetch_skid u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_skid_load),
    .i_pc     (r_addr),
    .i_inst   (i_inst_data),
    .i_unload (w_skid_unload),
    .i_clear  (w_skid_clear),
    .o_pc     (w_skid_pc),
    .o_inst   (w_skid_inst),
    .o_valid  (w_skid_valid)
  );

  // Next-state, request and presentation logic.
  always_comb begin
    w_state_next      = r_state;
    w_req_next        = r_req;
    w_addr_next       = r_addr;
    w_pc_next         = r_pc;
    w_inst_next       = r_inst;
    w_valid_next      = r_valid;
    w_mis_next        = r_mis;
    w_target_next     = r_target;
    w_target_mis_next = r_target_mis;
    w_skid_load       = 1'b0;
    w_skid_unload     = 1'b0;
    w_skid_clear      = 1'b0;
    w_launch          = 1'b0;

    case (r_state)
      RESET_WAIT: begin
        w_state_next = REQ;
        w_req_next   = 1'b1;
        w_addr_next  = RESET_PC;
      end

      REQ, SKID: begin
        if (redirect) begin
          w_valid_next = 1'b0;
          w_mis_next   = 1'b0;
          w_skid_clear = 1'b1;
          if (r_req && !i_inst_ack) begin
            // Memory still owes us a response: wait it out, then retarget.
            w_state_next      = FLUSH;
            w_target_next     = w_tgt_pc;
            w_target_mis_next = w_tgt_mis;
          end else begin
            w_launch = 1'b1;
          end
        end else if (r_state == SKID) begin
          if (!stall) begin
            w_pc_next     = w_skid_pc;
            w_inst_next   = w_skid_inst;
            w_valid_next  = w_skid_valid;
            w_skid_unload = 1'b1;
            w_req_next    = 1'b1;
            w_addr_next   = w_skid_pc + 32'd4;
            w_state_next  = REQ;
          end
        end else if (r_mis) begin
          // Parked on a misaligned target until the next redirect.
          w_state_next = REQ;
        end else if (stall) begin
          if (w_ack) begin
            w_skid_load  = 1'b1;
            w_req_next   = 1'b0;
            w_state_next = SKID;
          end
        end else if (w_ack) begin
          w_pc_next    = r_addr;
          w_inst_next  = i_inst_data;
          w_valid_next = 1'b1;
          w_addr_next  = r_addr + 32'd4;
          w_req_next   = 1'b1;
        end else begin
          w_valid_next = 1'b0;
        end
      end

      FLUSH: begin
        if (redirect) begin
          w_target_next     = w_tgt_pc;
          w_target_mis_next = w_tgt_mis;
        end
        if (w_ack) begin
          w_launch = 1'b1;
        end
      end

      default: begin
        w_state_next = RESET_WAIT;
      end
    endcase

    // Start fetching from a new target, or park on it if it is unfetchable.
    if (w_launch) begin
      w_state_next = REQ;
      if (w_src_mis) begin
        w_req_next   = 1'b0;
        w_valid_next = 1'b1;
        w_pc_next    = w_src_pc;
        w_inst_next  = NOP_INST;
        w_mis_next   = 1'b1;
      end else begin
        w_req_next  = 1'b1;
        w_addr_next = word_align(w_src_pc);
      end
    end
  end

  // State and datapath registers; reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= RESET_WAIT;
      r_req        <= 1'b0;
      r_addr       <= RESET_PC;
      r_pc         <= 32'd0;
      r_inst       <= 32'd0;
      r_valid      <= 1'b0;
      r_mis        <= 1'b0;
      r_target     <= 32'd0;
      r_target_mis <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_req        <= w_req_next;
      r_addr       <= w_addr_next;
      r_pc         <= w_pc_next;
      r_inst       <= w_inst_next;
      r_valid      <= w_valid_next;
      r_mis        <= w_mis_next;
      r_target     <= w_target_next;
      r_target_mis <= w_target_mis_next;
    end
  end

  assign i_inst_req  = r_req;
  assign i_inst_addr = r_addr;
  assign pc          = r_pc;
  assign inst        = r_inst;
  assign inst_valid  = r_valid;
`ifdef RV32I_FETCH_MISALIGN_EN
  assign misaligned  = r_mis;
`else
  assign misaligned  = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_fetch.sv
// tb_rv32i_fetch: directed and randomized checks of rv32i_fetch against a
// program-order scoreboard (fetched-but-not-presented queue).
module tb_rv32i_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_inst_req;
  logic [31:0] i_inst_addr;
  logic        i_inst_ack = 1'b0;
  logic [31:0] i_inst_data = 32'd0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        misaligned;

  always #5 clk = ~clk;

  rv32i_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_inst_req  (i_inst_req),
    .i_inst_addr (i_inst_addr),
    .i_inst_ack  (i_inst_ack),
    .i_inst_data (i_inst_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .pc          (pc),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .misaligned  (misaligned)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Scoreboard: instructions accepted from memory but not yet presented.
  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  logic [31:0] m_fetch;   // address the next kept fetch must have
  bit          m_flush;   // outstanding response is to be discarded

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_inst.delete();
    m_fetch = 32'h0000_0000;
    m_flush = 1'b0;
  endtask

  task automatic reset_values(input string tag);
    check_eq({tag, "_req"},   32'(i_inst_req), 32'd0);
    check_eq({tag, "_addr"},  i_inst_addr, 32'h0000_0000);
    check_eq({tag, "_pc"},    pc, 32'd0);
    check_eq({tag, "_inst"},  inst, 32'd0);
    check_eq({tag, "_valid"}, 32'(inst_valid), 32'd0);
    check_eq({tag, "_mis"},   32'(misaligned), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; i_inst_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'd0; i_inst_data = 32'd0;
    #1;
    reset_values("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rst_wait_req", 32'(i_inst_req), 32'd0);
    @(posedge clk); #1;
    check_eq("first_req", 32'(i_inst_req), 32'd1);
    check_eq("first_addr", i_inst_addr, 32'h0000_0000);
    check_eq("first_valid", 32'(inst_valid), 32'd0);
    model_reset();
  endtask

  // One clock of stimulus, then every output checked against the scoreboard.
  task automatic cycle(input bit a_ack, input logic [31:0] a_data, input bit a_stall,
                       input bit a_redir, input logic [31:0] a_rpc);
    logic        pre_req, pre_valid;
    logic [31:0] pre_addr, pre_pc, pre_inst, tgt;
    bit          acc, flush_done;
    @(negedge clk);
    pre_req = i_inst_req; pre_addr = i_inst_addr;
    pre_pc = pc; pre_inst = inst; pre_valid = inst_valid;
    i_inst_ack  = a_ack && pre_req;
    i_inst_data = a_data;
    stall       = a_stall;
    redirect    = a_redir;
    redirect_pc = a_rpc;
    @(posedge clk); #1;
    cyc++;
    tgt        = {a_rpc[31:2], 2'b00};
    acc        = pre_req && a_ack;
    flush_done = acc && m_flush && !a_redir;
    check_eq("addr_aligned", 32'(i_inst_addr[1:0]), 32'd0);
    check_eq("mis_low", 32'(misaligned), 32'd0);
    if (a_redir) begin
      check_eq("redir_valid", 32'(inst_valid), 32'd0);
      check_eq("redir_req", 32'(i_inst_req), 32'd1);
      if (pre_req && !a_ack) begin
        check_eq("flush_hold_addr", i_inst_addr, pre_addr);
        m_flush = 1'b1;
      end else begin
        check_eq("redir_addr", i_inst_addr, tgt);
        m_flush = 1'b0;
      end
      q_pc.delete(); q_inst.delete();
      m_fetch = tgt;
      $display("cycle %0d redirect to %h", cyc, tgt);
    end else begin
      if (acc && !m_flush) begin
        check_eq("fetch_addr", pre_addr, m_fetch);
        q_pc.push_back(m_fetch);
        q_inst.push_back(a_data);
        m_fetch = m_fetch + 32'd4;
      end
      if (flush_done) m_flush = 1'b0;
      if (pre_req && !acc) begin
        check_eq("req_stable", 32'(i_inst_req), 32'd1);
        check_eq("addr_stable", i_inst_addr, pre_addr);
      end else if (flush_done || !a_stall) begin
        check_eq("req_issue", 32'(i_inst_req), 32'd1);
        check_eq("req_addr", i_inst_addr, m_fetch);
      end else begin
        check_eq("req_quiet", 32'(i_inst_req), 32'd0);
      end
      if (a_stall) begin
        check_eq("hold_pc", pc, pre_pc);
        check_eq("hold_inst", inst, pre_inst);
        check_eq("hold_valid", 32'(inst_valid), 32'(pre_valid));
      end else if (q_pc.size() != 0) begin
        check_eq("present_valid", 32'(inst_valid), 32'd1);
        check_eq("present_pc", pc, q_pc[0]);
        check_eq("present_inst", inst, q_inst[0]);
        $display("cycle %0d present pc=%h inst=%h", cyc, q_pc[0], q_inst[0]);
        void'(q_pc.pop_front());
        void'(q_inst.pop_front());
      end else begin
        check_eq("bubble_valid", 32'(inst_valid), 32'd0);
      end
    end
  endtask

  initial begin
    bit          r_ack, r_stall, r_redir;
    logic [31:0] r_rpc;

    // Streaming from reset, one instruction per cycle.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 32'h0000_1000 + 32'(i), 1'b0, 1'b0, 32'd0);
      check_eq("stream_pc", pc, 32'(i * 4));
      check_eq("stream_addr", i_inst_addr, 32'((i + 1) * 4));
    end

    // Stall with an ack arriving: captured, released one cycle after stall drops.
    do_reset();
    cycle(1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 32'h1111_0004, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 32'h00A0_0093, 1'b1, 1'b0, 32'd0);
    check_eq("skid_req_off", 32'(i_inst_req), 32'd0);
    check_eq("skid_pc_frozen", pc, 32'h0000_0004);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    check_eq("skid_req_still_off", 32'(i_inst_req), 32'd0);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_eq("skid_out_inst", inst, 32'h00A0_0093);
    check_eq("skid_out_pc", pc, 32'h0000_0008);
    check_eq("skid_next_addr", i_inst_addr, 32'h0000_000C);

    // Redirect with request at 0x10 outstanding, ack two cycles later.
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, $urandom(), 1'b0, 1'b0, 32'd0);
    check_eq("pre_flush_addr", i_inst_addr, 32'h0000_0010);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0100);
    cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_eq("flush_no_valid", 32'(inst_valid), 32'd0);
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
    check_eq("flush_dropped", 32'(inst_valid), 32'd0);
    check_eq("flush_new_addr", i_inst_addr, 32'h0000_0100);

    // Redirect, stall and ack together: redirect wins.
    cycle(1'b1, 32'h2222_2222, 1'b1, 1'b1, 32'h0000_0100);
    check_eq("prio_valid", 32'(inst_valid), 32'd0);
    check_eq("prio_addr", i_inst_addr, 32'h0000_0100);

    // Address wrap at the top of the space.
    do_reset();
    cycle(1'b1, $urandom(), 1'b0, 1'b1, 32'hFFFF_FFF8);
    cycle(1'b1, 32'h3333_0000, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 32'h3333_0004, 1'b0, 1'b0, 32'd0);
    check_eq("wrap_addr", i_inst_addr, 32'h0000_0000);
    check_eq("wrap_pc", pc, 32'hFFFF_FFFC);

    // Redirect to a misaligned target (ack in the same cycle, nothing owed).
    do_reset();
`ifdef RV32I_FETCH_MISALIGN_EN
    @(negedge clk);
    i_inst_ack = 1'b1; i_inst_data = 32'h4444_4444; redirect = 1'b1;
    redirect_pc = 32'h0000_0102; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("mis_req", 32'(i_inst_req), 32'd0);
      check_eq("mis_valid", 32'(inst_valid), 32'd1);
      check_eq("mis_pc", pc, 32'h0000_0102);
      check_eq("mis_inst", inst, 32'h0000_0013);
      check_eq("mis_flag", 32'(misaligned), 32'd1);
      @(negedge clk);
      i_inst_ack = 1'b0; redirect = 1'b0; stall = (i == 0);
    end
    do_reset();
`else
    cycle(1'b1, $urandom(), 1'b0, 1'b1, 32'h0000_0102);
    check_eq("mis_off_addr", i_inst_addr, 32'h0000_0100);
    check_eq("mis_off_flag", 32'(misaligned), 32'd0);
`endif

    // Reset pulsed mid-request, late ack must be ignored.
    cycle(1'b1, $urandom(), 1'b0, 1'b0, 32'd0);
    cycle(1'b1, $urandom(), 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    reset_values("async_rst");
    i_inst_ack = 1'b1; i_inst_data = 32'hBAD0_BAD0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("late_ack_req", 32'(i_inst_req), 32'd1);
    check_eq("late_ack_addr", i_inst_addr, 32'h0000_0000);
    check_eq("late_ack_valid", 32'(inst_valid), 32'd0);
    model_reset();

    // Randomized traffic against the scoreboard.
    for (int k = 0; k < 400; k++) begin
      r_ack   = ($urandom_range(0, 99) < 60);
      r_stall = ($urandom_range(0, 99) < 25);
      r_redir = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 3) == 0) r_rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
      else                           r_rpc = $urandom() & 32'h0000_FFFC;
      cycle(r_ack, $urandom(), r_stall, r_redir, r_rpc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
